// File: rtl/xgmii_pkg.sv
// Shared XGMII constants, fault-state encoding and the
// column fault-sequence decoder used by the link supervisor.
package xgmii_pkg;

  localparam logic [7:0] XGMII_IDLE  = 8'h07;
  localparam logic [7:0] XGMII_START = 8'hFB;
  localparam logic [7:0] XGMII_TERM  = 8'hFD;
  localparam logic [7:0] XGMII_SEQ   = 8'h9C;
  localparam logic [7:0] LF          = 8'h01;
  localparam logic [7:0] RF          = 8'h02;

  localparam logic [63:0] IDLE_WORD = {8{XGMII_IDLE}};
  localparam logic [63:0] RF_WORD   = 64'h0200009C_0200009C;
  localparam logic [7:0]  RF_CTRL   = 8'h11;

  // LED blink toggles when this bit of the shared counter flips
  localparam int BLINK_BIT = 22;

  typedef enum logic [1:0] {
    FS_OK     = 2'b00,
    FS_LOCAL  = 2'b01,
    FS_REMOTE = 2'b10
  } fault_state_t;

  typedef enum logic [1:0] {
    TX_PASS = 2'b00,
    TX_IDLE = 2'b01,
    TX_RF   = 2'b10
  } tx_mode_t;

  // returns {remote, local} for one 4-lane column
  function automatic logic [1:0] col_fault(
    input logic [31:0] d,
    input logic [2:0]  c
  );
    logic hdr;
    hdr = (c == 3'b001) && (d[7:0] == XGMII_SEQ)
       && (d[23:8] == 16'h0000);
    return {hdr && (d[31:24] == RF),
            hdr && (d[31:24] == LF)};
  endfunction

endpackage

// File: rtl/xgmii_link_port.sv
// One XGMII port: RX fault detection, link-fault FSM,
// block-lock debounce and frame-safe registered TX mux.
module xgmii_link_port
  import xgmii_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1024,
  parameter int FAULT_CNT    = 4,
  parameter int WINDOW_CYC   = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lock,
  input  logic [63:0] rxd,
  input  logic [7:0]  rxc,
  input  logic [63:0] mac_txd,
  input  logic [7:0]  mac_txc,
  input  logic        port_enable,
  output logic [63:0] txd,
  output logic [7:0]  txc,
  output logic        link_up,
  output logic [1:0]  fault_state
);

  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int SW = $clog2(FAULT_CNT + 1);
  localparam int WW = $clog2(WINDOW_CYC + 1);

  localparam logic [DW-1:0] DB_MAX  = DW'(DEBOUNCE_CYC);
  localparam logic [SW-1:0] SEQ_MAX = SW'(FAULT_CNT);
  localparam logic [WW-1:0] WIN_MAX = WW'(WINDOW_CYC);

  fault_state_t  state, state_n;
  logic [SW-1:0] seq_cnt, seq_n;
  logic          last_rf, last_n;
  logic [WW-1:0] win_cnt, win_n;
  logic [DW-1:0] db_cnt;

  logic [1:0] f0, f1;
  logic [3:0] hit;
  logic       any_seq;
  logic       rxc_unused;

  tx_mode_t want, eff, cur_mode;
  logic     in_frame;
  logic     start, term;

  // ordered-set control lives on lane 0 of a column only
  assign rxc_unused = rxc[3] ^ rxc[7];

  assign f0 = col_fault(rxd[31:0],  rxc[2:0]);
  assign f1 = col_fault(rxd[63:32], rxc[6:4]);
  // locals first so a remote in the same word counts last
  assign hit     = {f1[1], f0[1], f1[0], f0[0]};
  assign any_seq = |hit;

  assign fault_state = state;

  // fault FSM and sequence/window counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= FS_OK;
      seq_cnt <= '0;
      last_rf <= 1'b0;
      win_cnt <= '0;
    end else begin
      state   <= state_n;
      seq_cnt <= seq_n;
      last_rf <= last_n;
      win_cnt <= win_n;
    end
  end

  // next state: walk the word's sequences, then the window
  always_comb begin
    state_n = state;
    seq_n   = seq_cnt;
    last_n  = last_rf;
    win_n   = win_cnt;
    for (int k = 0; k < 4; k++) begin
      if (hit[k]) begin
        if ((k >= 2) == last_n) begin
          if (seq_n != SEQ_MAX) seq_n = seq_n + SW'(1);
        end else begin
          seq_n  = SW'(1);
          last_n = (k >= 2);
        end
        if (seq_n == SEQ_MAX)
          state_n = last_n ? FS_REMOTE : FS_LOCAL;
      end
    end
    if (any_seq)
      win_n = '0;
    else if (win_cnt != WIN_MAX)
      win_n = win_cnt + WW'(1);
    if (win_n == WIN_MAX) begin
      seq_n   = '0;
      state_n = FS_OK;
    end
    if (!lock) state_n = FS_LOCAL;
  end

  // output decode: TX mode the current fault state asks for
  always_comb begin
    want = TX_IDLE;
    unique case (1'b1)
      (state == FS_LOCAL):  want = TX_RF;
      (state == FS_REMOTE): want = TX_IDLE;
      default: want = port_enable ? TX_PASS : TX_IDLE;
    endcase
  end

  // lock debounce and registered link_up
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt  <= '0;
      link_up <= 1'b0;
    end else begin
      if (!lock)
        db_cnt <= '0;
      else if (db_cnt != DB_MAX)
        db_cnt <= db_cnt + DW'(1);
      link_up <= (db_cnt == DB_MAX) && (state == FS_OK);
    end
  end

  // frame delimiters on the MAC stream
  always_comb begin
    start = (mac_txc[0] && mac_txd[7:0] == XGMII_START)
         || (mac_txc[4] && mac_txd[39:32] == XGMII_START);
    term = 1'b0;
    for (int i = 0; i < 8; i++)
      if (mac_txc[i] && mac_txd[8*i +: 8] == XGMII_TERM)
        term = 1'b1;
  end

  // mode actually applied to this word, never cutting a frame
  always_comb begin
    eff = cur_mode;
    if (cur_mode == TX_PASS) begin
      if (want != TX_PASS && !in_frame) eff = want;
    end else if (want == TX_PASS) begin
      if (!start) eff = TX_PASS;
    end else begin
      eff = want;
    end
  end

  // registered TX word, applied mode and frame tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txd      <= IDLE_WORD;
      txc      <= 8'hFF;
      cur_mode <= TX_IDLE;
      in_frame <= 1'b0;
    end else begin
      cur_mode <= eff;
      if (start && !term)
        in_frame <= 1'b1;
      else if (term)
        in_frame <= 1'b0;
      unique case (1'b1)
        (eff == TX_PASS): begin
          txd <= mac_txd;
          txc <= mac_txc;
        end
        (eff == TX_RF): begin
          txd <= RF_WORD;
          txc <= RF_CTRL;
        end
        default: begin
          txd <= IDLE_WORD;
          txc <= 8'hFF;
        end
      endcase
    end
  end

endmodule

// File: rtl/xgmii_link_supervisor.sv
// NPORTS independent XGMII link supervisors sharing one
// LED blink counter for fault indication.
module xgmii_link_supervisor
  import xgmii_pkg::*;
#(
  parameter int NPORTS       = 4,
  parameter int DEBOUNCE_CYC = 1024,
  parameter int FAULT_CNT    = 4,
  parameter int WINDOW_CYC   = 64
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic [8*NPORTS-1:0]   xphy_status,
  input  logic [64*NPORTS-1:0]  xgmii_rxd,
  input  logic [8*NPORTS-1:0]   xgmii_rxc,
  input  logic [64*NPORTS-1:0]  mac_txd,
  input  logic [8*NPORTS-1:0]   mac_txc,
  input  logic [NPORTS-1:0]     port_enable,
  output logic [64*NPORTS-1:0]  xgmii_txd,
  output logic [8*NPORTS-1:0]   xgmii_txc,
  output logic [NPORTS-1:0]     link_up,
  output logic [2*NPORTS-1:0]   fault_state,
  output logic [NPORTS-1:0]     led
);

  localparam int BW = BLINK_BIT + 1;

  logic [BW-1:0]         blink_cnt;
  logic                  blink;
  logic [7*NPORTS-1:0]   status_unused;

  assign blink = blink_cnt[BLINK_BIT];

  // free-running blink timebase shared by all ports
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) blink_cnt <= '0;
    else         blink_cnt <= blink_cnt + BW'(1);
  end

  for (genvar i = 0; i < NPORTS; i++) begin : g_port
    assign status_unused[7*i +: 7] = xphy_status[8*i+1 +: 7];

    xgmii_link_port #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .FAULT_CNT    (FAULT_CNT),
      .WINDOW_CYC   (WINDOW_CYC)
    ) u_port (
      .clk         (sys_clk),
      .rst         (sys_rst),
      .lock        (xphy_status[8*i]),
      .rxd         (xgmii_rxd[64*i +: 64]),
      .rxc         (xgmii_rxc[8*i +: 8]),
      .mac_txd     (mac_txd[64*i +: 64]),
      .mac_txc     (mac_txc[8*i +: 8]),
      .port_enable (port_enable[i]),
      .txd         (xgmii_txd[64*i +: 64]),
      .txc         (xgmii_txc[8*i +: 8]),
      .link_up     (link_up[i]),
      .fault_state (fault_state[2*i +: 2])
    );

    assign led[i] = (fault_state[2*i +: 2] != 2'b00)
                  ? blink : link_up[i];
  end

endmodule

// File: tb/tb_xgmii_link_supervisor.sv
// Directed bench for xgmii_link_supervisor: debounce, fault
// FSM, frame-safe TX switching, enable and async reset.
module tb_xgmii_link_supervisor;

  localparam int NP = 4;
  localparam logic [63:0] IDLE_W = 64'h0707070707070707;
  localparam logic [63:0] RF_W   = 64'h0200009C_0200009C;
  localparam logic [63:0] LF2    = 64'h0100009C_0100009C;
  localparam logic [63:0] RF1    = 64'h07070707_0200009C;
  localparam logic [63:0] LF1    = 64'h07070707_0100009C;
  localparam logic [63:0] SFD    = 64'hD5555555_555555FB;
  localparam logic [63:0] TRM    = 64'h07070707_070707FD;

  logic              sys_clk = 1'b0;
  logic              sys_rst;
  logic [8*NP-1:0]   xphy_status;
  logic [64*NP-1:0]  xgmii_rxd;
  logic [8*NP-1:0]   xgmii_rxc;
  logic [64*NP-1:0]  mac_txd;
  logic [8*NP-1:0]   mac_txc;
  logic [NP-1:0]     port_enable;
  logic [64*NP-1:0]  xgmii_txd;
  logic [8*NP-1:0]   xgmii_txc;
  logic [NP-1:0]     link_up;
  logic [2*NP-1:0]   fault_state;
  logic [NP-1:0]     led;

  int checks = 0;
  int errors = 0;

  xgmii_link_supervisor #(
    .NPORTS       (NP),
    .DEBOUNCE_CYC (1024),
    .FAULT_CNT    (4),
    .WINDOW_CYC   (64)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .xphy_status (xphy_status),
    .xgmii_rxd   (xgmii_rxd),
    .xgmii_rxc   (xgmii_rxc),
    .mac_txd     (mac_txd),
    .mac_txc     (mac_txc),
    .port_enable (port_enable),
    .xgmii_txd   (xgmii_txd),
    .xgmii_txc   (xgmii_txc),
    .link_up     (link_up),
    .fault_state (fault_state),
    .led         (led)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic step(input int n = 1);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_rx(input int p, input logic [63:0] d,
                        input logic [7:0] c);
    xgmii_rxd[64*p +: 64] = d;
    xgmii_rxc[8*p +: 8]   = c;
  endtask

  task automatic set_mac(input int p, input logic [63:0] d,
                         input logic [7:0] c);
    mac_txd[64*p +: 64] = d;
    mac_txc[8*p +: 8]   = c;
  endtask

  function automatic logic [63:0] txd_of(input int p);
    return xgmii_txd[64*p +: 64];
  endfunction

  function automatic logic [7:0] txc_of(input int p);
    return xgmii_txc[8*p +: 8];
  endfunction

  initial begin
    logic [63:0] dw;
    sys_rst     = 1'b1;
    xphy_status = {NP{8'h01}};
    port_enable = '1;
    for (int p = 0; p < NP; p++) begin
      set_rx(p, IDLE_W, 8'hFF);
      set_mac(p, IDLE_W, 8'hFF);
    end
    step(2);
    chk("rst_txd0", txd_of(0), IDLE_W);
    chk("rst_txc0", {56'h0, txc_of(0)}, 64'hFF);
    chk("rst_link", {60'h0, link_up}, 64'h0);
    chk("rst_fault", {56'h0, fault_state}, 64'h0);
    chk("rst_led", {60'h0, led}, 64'h0);

    // debounce: link_up after DEBOUNCE_CYC+1 edges
    set_mac(0, 64'h1122334455667788, 8'h00);
    sys_rst = 1'b0;
    step(1024);
    chk("db_early", {60'h0, link_up}, 64'h0);
    step(1);
    chk("db_up", {60'h0, link_up}, 64'hF);
    chk("db_fault", {56'h0, fault_state}, 64'h0);
    chk("db_led", {60'h0, led}, 64'hF);
    chk("pass_a", txd_of(0), 64'h1122334455667788);
    set_mac(0, 64'h0123456789ABCDEF, 8'h00);
    step(1);
    chk("pass_b", txd_of(0), 64'h0123456789ABCDEF);

    // local fault on port 1, then window recovery
    set_rx(1, LF2, 8'h11);
    step(1);
    chk("lf_3seq", {62'h0, fault_state[3:2]}, 64'h0);
    step(1);
    chk("lf_enter", {62'h0, fault_state[3:2]}, 64'h1);
    chk("lf_link_lag", {63'h0, link_up[1]}, 64'h1);
    set_rx(1, IDLE_W, 8'hFF);
    set_mac(1, 64'hA1A2A3A4A5A6A7A8, 8'h00);
    step(1);
    chk("lf_link", {63'h0, link_up[1]}, 64'h0);
    chk("lf_txd", txd_of(1), RF_W);
    chk("lf_txc", {56'h0, txc_of(1)}, 64'h11);
    chk("lf_led", {63'h0, led[1]}, 64'h0);
    step(62);
    chk("win_63", {62'h0, fault_state[3:2]}, 64'h1);
    step(1);
    chk("win_64", {62'h0, fault_state[3:2]}, 64'h0);
    step(1);
    chk("win_pass", txd_of(1), 64'hA1A2A3A4A5A6A7A8);
    chk("win_link", {63'h0, link_up[1]}, 64'h1);

    // interleaved RF/LF reload, then 4 RF in a row
    set_mac(2, 64'hB0B1B2B3B4B5B6B7, 8'h00);
    for (int i = 0; i < 3; i++) begin
      set_rx(2, RF1, 8'hF1);
      step(1);
      set_rx(2, LF1, 8'hF1);
      step(1);
    end
    chk("mix_ok", {62'h0, fault_state[5:4]}, 64'h0);
    set_rx(2, RF1, 8'hF1);
    step(3);
    chk("rf_3", {62'h0, fault_state[5:4]}, 64'h0);
    step(1);
    chk("rf_4", {62'h0, fault_state[5:4]}, 64'h2);
    set_rx(2, IDLE_W, 8'hFF);
    step(1);
    chk("rf_txd", txd_of(2), IDLE_W);
    chk("rf_txc", {56'h0, txc_of(2)}, 64'hFF);
    chk("rf_link", {63'h0, link_up[2]}, 64'h0);

    // fault mid-frame on port 3 waits for Terminate
    set_mac(3, SFD, 8'h01);
    step(1);
    chk("fr_start", txd_of(3), SFD);
    for (int i = 0; i < 20; i++) begin
      dw = 64'hDA7A000000000000 | 64'(i);
      set_mac(3, dw, 8'h00);
      if (i == 4 || i == 5) set_rx(3, LF2, 8'h11);
      else                  set_rx(3, IDLE_W, 8'hFF);
      step(1);
      chk("fr_data", txd_of(3), dw);
      if (i == 6)
        chk("fr_fault", {62'h0, fault_state[7:6]}, 64'h1);
    end
    set_mac(3, TRM, 8'hFF);
    step(1);
    chk("fr_term", txd_of(3), TRM);
    chk("fr_termc", {56'h0, txc_of(3)}, 64'hFF);
    set_mac(3, 64'hEEEEEEEEEEEEEEEE, 8'h00);
    step(1);
    chk("fr_after", txd_of(3), RF_W);
    chk("fr_afterc", {56'h0, txc_of(3)}, 64'h11);

    // lock loss on port 1
    xphy_status[8] = 1'b0;
    step(1);
    chk("ll_fault", {62'h0, fault_state[3:2]}, 64'h1);
    chk("ll_lag", {63'h0, link_up[1]}, 64'h1);
    xphy_status[8] = 1'b1;
    step(1);
    chk("ll_link", {63'h0, link_up[1]}, 64'h0);

    // port_enable on port 0
    port_enable[0] = 1'b0;
    step(1);
    chk("en_idle", txd_of(0), IDLE_W);
    chk("en_idlec", {56'h0, txc_of(0)}, 64'hFF);
    port_enable[0] = 1'b1;
    step(1);
    chk("en_pass", txd_of(0), 64'h0123456789ABCDEF);

    // async reset in the middle of a frame
    set_mac(0, SFD, 8'h01);
    step(1);
    chk("ar_start", txd_of(0), SFD);
    set_mac(0, 64'h5A5A5A5A5A5A5A5A, 8'h00);
    step(1);
    #2 sys_rst = 1'b1;
    #1;
    chk("ar_txd", txd_of(0), IDLE_W);
    chk("ar_txc", {56'h0, txc_of(0)}, 64'hFF);
    chk("ar_link", {60'h0, link_up}, 64'h0);
    chk("ar_fault", {56'h0, fault_state}, 64'h0);
    step(2);
    for (int p = 0; p < NP; p++) set_rx(p, IDLE_W, 8'hFF);
    sys_rst = 1'b0;
    set_mac(0, 64'h3C3C3C3C3C3C3C3C, 8'h00);
    step(1);
    chk("ar_pass", txd_of(0), 64'h3C3C3C3C3C3C3C3C);
    step(1023);
    chk("ar_db_early", {60'h0, link_up}, 64'h0);
    step(1);
    chk("ar_db_up", {60'h0, link_up}, 64'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
